// File: rtl/add_arbiter_pkg.sv
// Shared definitions for the add_arbiter block: default sizes, response-slot
// state encoding and the id-width helper used by every user of the block.
package add_arbiter_pkg;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Width of an encoded requester index; never narrower than one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/add_arbiter_rr_pick.sv
// Round-robin selector: starting just after last_grant, picks the first set
// request and returns it both one-hot and encoded.
module rr_pick
    import add_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = id_width(N_REQ_DEF)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last_grant,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);

    logic            found;
    logic [ID_W-1:0] pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        // k runs 1..N_REQ so last_grant itself is examined last.
        for (int k = 1; k <= N_REQ; k++) begin
            pos = ID_W'((int'(last_grant) + k) % N_REQ);
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = pos;
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// N-requester front end sharing a single W-bit adder behind a one-entry
// response register; round-robin grant, drain and refill in the same cycle.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    localparam int ID_W = id_width(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_a,
    input  logic [N_REQ*W-1:0]   req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [W-1:0]         rsp_sum,
    output logic                 rsp_carry,
    output logic [ID_W-1:0]      rsp_id
);

    state_e          state_q, state_d;
    logic [W-1:0]    sum_q, sum_d;
    logic            carry_q, carry_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [ID_W-1:0] last_grant_q, last_grant_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [ID_W-1:0]  pick_idx;
    logic             slot_free;
    logic             req_fire;
    logic             rsp_fire;
    logic [W-1:0]     a_sel, b_sel;
    logic [W:0]       sum_full;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .gnt        (pick_gnt),
        .idx        (pick_idx)
    );

    assign rsp_valid = (state_q == FULL);
    assign rsp_sum   = sum_q;
    assign rsp_carry = carry_q;
    assign rsp_id    = id_q;

    assign slot_free = (state_q == EMPTY) || rsp_ready;
    assign req_ready = (!rst && slot_free) ? pick_gnt : '0;
    assign req_fire  = |req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // One-hot AND-OR operand mux keeps a single adder for all requesters.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt[i]) begin
                a_sel = a_sel | req_a[i*W +: W];
                b_sel = b_sel | req_b[i*W +: W];
            end
        end
    end

    assign sum_full = {1'b0, a_sel} + {1'b0, b_sel};

    always_comb begin
        state_d      = state_q;
        sum_d        = sum_q;
        carry_d      = carry_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        if (req_fire) begin
            state_d      = FULL;
            sum_d        = sum_full[W-1:0];
            carry_d      = sum_full[W];
            id_d         = pick_idx;
            last_grant_d = pick_idx;
        end else if (rsp_fire) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            sum_q        <= '0;
            carry_q      <= 1'b0;
            id_q         <= '0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            carry_q      <= carry_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Directed bench for add_arbiter with N_REQ=4, W=8.
module tb_add_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic [1:0]  rsp_id;

    int n_cmp = 0;
    int n_bad = 0;

    add_arbiter #(.N_REQ(4), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_carry (rsp_carry),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_ops(i, 8'h10 * i[7:0] + 8'h01, i[7:0]);
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL reset_req_ready cycle %0d got %b exp 0000", c, req_ready);
            end
            n_cmp++;
            if (rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_rsp_valid cycle %0d got %b exp 0", c, rsp_valid);
            end
        end
        n_cmp++;
        if ({rsp_sum, rsp_carry, rsp_id} !== 11'd0) begin
            n_bad++;
            $display("FAIL reset_outputs got sum %h carry %b id %0d exp 0/0/0", rsp_sum, rsp_carry, rsp_id);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL reset_first_grant got %b exp 0001", req_ready);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h01) begin
            n_bad++;
            $display("FAIL reset_first_result got v%b id %0d sum %h exp v1 id 0 sum 01", rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_single();
        do_reset();
        set_ops(2, 8'h7F, 8'h01);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL single_ready got %b exp 0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 8'h80 || rsp_carry !== 1'b0 || rsp_id !== 2'd2) begin
            n_bad++;
            $display("FAIL single_result got v%b sum %h c%b id %0d exp v1 sum 80 c0 id 2",
                     rsp_valid, rsp_sum, rsp_carry, rsp_id);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drain got %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_carry();
        do_reset();
        set_ops(1, 8'hFF, 8'h02);
        req_valid = 4'b0010;
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++;
        if (rsp_sum !== 8'h01 || rsp_carry !== 1'b1 || rsp_id !== 2'd1) begin
            n_bad++;
            $display("FAIL carry_wrap got sum %h c%b id %0d exp sum 01 c1 id 1", rsp_sum, rsp_carry, rsp_id);
        end
        set_ops(3, 8'hFF, 8'hFF);
        req_valid = 4'b1000;
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++;
        if (rsp_sum !== 8'hFE || rsp_carry !== 1'b1 || rsp_id !== 2'd3) begin
            n_bad++;
            $display("FAIL carry_max got sum %h c%b id %0d exp sum fe c1 id 3", rsp_sum, rsp_carry, rsp_id);
        end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_sum [4];
        exp_sum[0] = 8'h01; exp_sum[1] = 8'h12; exp_sum[2] = 8'h23; exp_sum[3] = 8'h34;
        do_reset();
        set_ops(0, 8'h00, 8'h01);
        set_ops(1, 8'h10, 8'h02);
        set_ops(2, 8'h20, 8'h03);
        set_ops(3, 8'h30, 8'h04);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(c % 4) || rsp_sum !== exp_sum[c % 4]) begin
                n_bad++;
                $display("FAIL fairness cycle %0d got v%b id %0d sum %h exp v1 id %0d sum %h",
                         c, rsp_valid, rsp_id, rsp_sum, c % 4, exp_sum[c % 4]);
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ops(0, 8'h20, 8'h05);
        set_ops(1, 8'h30, 8'h03);
        set_ops(2, 8'h40, 8'h04);
        set_ops(3, 8'h50, 8'h06);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL bp_ready_initial got %b exp 0000", req_ready);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 8'h25 || rsp_carry !== 1'b0 ||
                rsp_id !== 2'd0 || req_ready !== 4'b0000) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d got v%b sum %h c%b id %0d rdy %b exp v1 sum 25 c0 id 0 rdy 0000",
                         c, rsp_valid, rsp_sum, rsp_carry, rsp_id, req_ready);
            end
        end
        rsp_ready = 1'b1;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL bp_release_grant got %b exp 0010", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 8'h33) begin
            n_bad++;
            $display("FAIL bp_refill got v%b id %0d sum %h exp v1 id 1 sum 33", rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    task automatic test_withdraw();
        do_reset();
        set_ops(1, 8'h01, 8'h01);
        set_ops(2, 8'h0A, 8'h0B);
        req_valid = 4'b0110;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL withdraw_before got %b exp 0010", req_ready);
        end
        req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL withdraw_move got %b exp 0100", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++;
        if (rsp_id !== 2'd2 || rsp_sum !== 8'h15) begin
            n_bad++;
            $display("FAIL withdraw_result got id %0d sum %h exp id 2 sum 15", rsp_id, rsp_sum);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_ops(2, 8'h33, 8'h44);
        req_valid = 4'b0100;
        step();
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
        step();
        rst = 1'b1;
        req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (req_ready !== 4'b0000) begin
            n_bad++;
            $display("FAIL mid_reset_ready got %b exp 0000", req_ready);
        end
        step();
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 8'h00 || rsp_id !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_reset_drop got v%b sum %h id %0d exp v0 sum 00 id 0", rsp_valid, rsp_sum, rsp_id);
        end
        rst = 1'b0;
        rsp_ready = 1'b1;
        set_ops(0, 8'h11, 8'h22);
        #1;
        n_cmp++;
        if (req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL mid_reset_regrant got %b exp 0001", req_ready);
        end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h33) begin
            n_bad++;
            $display("FAIL mid_reset_result got v%b id %0d sum %h exp v1 id 0 sum 33", rsp_valid, rsp_id, rsp_sum);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'b0000;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_carry();
        test_fairness();
        test_backpressure();
        test_withdraw();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the adder; legal range 2..8.
REQ-002 Parameter W, default 8: operand and sum width in bits.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  N_REQ  per-requester operand-pair valid.
REQ-006 req_a  input  N_REQ*W  packed operand A; requester i occupies bits [i*W +: W].
REQ-007 req_b  input  N_REQ*W  packed operand B; same packing as req_a.
REQ-008 req_ready  output  N_REQ  per-requester accept; one-hot or zero.
REQ-009 rsp_valid  output  1  result register holds an undelivered result.
REQ-010 rsp_ready  input  1  consumer accepts the result.
REQ-011 rsp_sum  output  W  low W bits of A+B.
REQ-012 rsp_carry  output  1  carry-out of A+B (bit W).
REQ-013 rsp_id  output  clog2(N_REQ)  index of the requester that produced the result.

Function
REQ-014 Block SHALL contain exactly one W-bit adder, shared by all requesters.
REQ-015 Request transfer SHALL occur on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-016 Response transfer SHALL occur on a cycle where rsp_valid and rsp_ready are both 1.
REQ-017 Output slot free = rsp_valid==0 or rsp_ready==1 (drain and refill in the same cycle).
REQ-018 When the slot is free and any req_valid is set, req_ready SHALL assert for exactly one granted requester; otherwise req_ready SHALL be 0.
REQ-019 Grant SHALL be round-robin: search starts at index (last_grant+1) mod N_REQ and takes the first set req_valid.
REQ-020 last_grant SHALL update only on a request transfer; after reset it SHALL be N_REQ-1, so index 0 has top priority.
REQ-021 req_ready MAY depend combinationally on req_valid and rsp_ready; it SHALL NOT depend on req_a/req_b.
REQ-022 On a request transfer, {rsp_carry, rsp_sum} SHALL become A+B (W+1 bits, unsigned), rsp_id the granted index, and rsp_valid 1, at the next rising edge; latency 1 cycle.
REQ-023 A response transfer with no request transfer in the same cycle SHALL clear rsp_valid next cycle.
REQ-024 While rsp_valid==1 and rsp_ready==0, rsp_sum, rsp_carry and rsp_id SHALL hold stable.
REQ-025 Sustained throughput SHALL be one result per cycle when rsp_ready is held at 1.
REQ-026 Overflow handling: sum wraps modulo 2^W; the carry is reported and never saturates.
REQ-027 A requester that deasserts req_valid before transfer SHALL lose no state; grant moves to the next valid requester.
REQ-028 State machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- EMPTY -> FULL on a request transfer.
- FULL -> FULL on a request transfer, or on rsp_ready=0.
- FULL -> EMPTY on a response transfer without a request transfer.

Reset
REQ-029 With rst=1 at a clock edge, the following SHALL be set:
- rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0
- last_grant=N_REQ-1
- state EMPTY
REQ-030 While rst=1, req_ready SHALL be 0 and no transfer SHALL be counted.
REQ-031 Reset mid-operation SHALL discard any pending result without delivering it.

Structure
REQ-032 A shared package SHALL hold the following, so upstream and downstream blocks use one definition:
- default N_REQ and W constants
- the state enumeration {EMPTY, FULL}
- a function computing the id width
REQ-033 The round-robin selector SHALL be one sub-module, rr_pick. Inputs: request vector and last_grant. Outputs: one-hot grant and encoded index.

Verification
REQ-034 Reset: assert rst for 2 cycles with all req_valid=1 -> req_ready=0 and rsp_valid=0 throughout; after release, first grant goes to index 0.
REQ-035 Single request: req_valid=4'b0100, a2=8'h7F, b2=8'h01, rsp_ready=1 -> next cycle rsp_valid=1, rsp_sum=8'h80, rsp_carry=0, rsp_id=2.
REQ-036 Carry wrap: requester 1 sends a=8'hFF, b=8'h02 -> rsp_sum=8'h01, rsp_carry=1, rsp_id=1.
REQ-037 Fairness: all four req_valid held high, rsp_ready=1 for 8 cycles -> rsp_id sequence 0,1,2,3,0,1,2,3, one result per cycle.
REQ-038 Backpressure: rsp_ready=0 for 3 cycles after a result -> req_ready=0 and outputs stable; rsp_ready=1 -> result drained and a new grant made in the same cycle.
REQ-039 Reset mid-operation: rst=1 while rsp_valid=1 and rsp_ready=0 -> result dropped, rsp_valid=0 next cycle, last_grant restored so index 0 wins next.
